keypad_entry_decoder: RTL and testbench
=======================================

Name: keypad_entry_decoder

Overview:
- Sits directly downstream of the keypad column scanner and consumes its per-scan key bitmap and valid strobe.
- Debounces each scan, turns a clean single-key press into a one-cycle key event, and encodes the key index.
- Assembles decimal digits into a binary frequency value committed with '#'; keys A–D select a waveform mode.
- Feeds the frequency generator control logic.

Parameters:
- N_COLUMN, 4, keypad columns; only 4 supported.
- N_ROW, 4, keypad rows; only 4 supported.
- DEBOUNCE_SAMPLES, 3, consecutive identical scans required to accept a pattern (≥1).
- MAX_DIGITS, 6, maximum digits per entry.
- VALUE_WIDTH, 20, entry/value width; must satisfy 2^VALUE_WIDTH > 10^MAX_DIGITS−1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- keys  in  N_COLUMN*N_ROW  scan bitmap; bit index = col*N_ROW+row; 1 = pressed.
- keys_valid  in  1  one-cycle strobe; keys is valid this cycle.
- key_strobe  out  1  one-cycle pulse on an accepted key press.
- key_code  out  4  index of the accepted key; held until the next strobe.
- entry  out  VALUE_WIDTH  live value being typed.
- digit_count  out  3  digits currently in entry.
- value  out  VALUE_WIDTH  last committed value; held.
- value_valid  out  1  one-cycle pulse when value updates.
- mode  out  2  selected mode, A=0 B=1 C=2 D=3; held.
- mode_valid  out  1  one-cycle pulse when mode is written.
- entry_overflow  out  1  one-cycle pulse when a digit is rejected.

Behaviour:
- Reset:
  - All outputs 0.
  - last_sample=0, stable_cnt=0, FSM=RELEASED.
  - keys_valid is ignored during reset.
- Debounce (acts only on cycles with keys_valid=1):
  - match = (keys==last_sample).
  - new_cnt = match ? min(stable_cnt+1, DEBOUNCE_SAMPLES−1) : 0.
  - Register last_sample<=keys and stable_cnt<=new_cnt.
  - stable = keys_valid && new_cnt==DEBOUNCE_SAMPLES−1.
  - With DEBOUNCE_SAMPLES=1, every sample is stable.
- FSM RELEASED:
  - stable && keys one-hot → key_strobe=1 and key_code=bit index at the same edge, then go to PRESSED.
  - stable && keys nonzero but not one-hot → go to PRESSED with no strobe (multi-key lockout).
  - stable && keys==0 → stay in RELEASED.
- FSM PRESSED:
  - stable && keys==0 → go to RELEASED.
  - Any other input → stay; no further strobes until a clean release.
- Key map (index → function):
  - Digits: 0→'1', 4→'2', 8→'3', 1→'4', 5→'5', 9→'6', 2→'7', 6→'8', 10→'9', 7→'0'.
  - 3→'*', 11→'#', 12→'A', 13→'B', 14→'C', 15→'D'.
- Entry update occurs one clock after key_strobe; all resulting pulses last one cycle.
- Digit key:
  - If digit_count<MAX_DIGITS: entry<=entry*10+d, digit_count+1.
  - Otherwise entry is unchanged and entry_overflow pulses.
  - Product is computed VALUE_WIDTH+4 wide, then truncated; no truncation can occur under the width rule.
- '*': entry<=0, digit_count<=0; value is unchanged.
- '#':
  - If digit_count>0: value<=entry, value_valid pulses, entry<=0, digit_count<=0.
  - If digit_count==0: no action, no pulse.
- A–D: mode<=index−12, mode_valid pulses. A mode key does not affect entry.
- Latency: accepting scan edge → key_strobe high for the next cycle → entry/value/mode outputs valid one cycle later.
- Reset mid-operation:
  - Everything clears as above.
  - A key held through reset is re-accepted as a new press after DEBOUNCE_SAMPLES scans.
- keys_valid spacing is arbitrary, including back-to-back cycles. Internal pipeline throughput is 1 event per cycle, so no event is ever lost.

Test Plan:
1. keys=16'h0020 for 3 strobes, then 16'h0000 for 3 → exactly one key_strobe with key_code=5; next cycle entry=5, digit_count=1.
2. Bounce sequence 0020,0000,0020,0020,0020 → single key_strobe, coincident with the 5th sample's edge only; no strobe earlier.
3. Press '1','2','3','#' (indices 0,4,8,11), each with clean release → value=123, one value_valid pulse, entry=0, digit_count=0.
4. Press '9' seven times, then '#' → entry_overflow pulses on the 7th press only; value=999999.
5. keys=16'h0021 held for 5 scans → no strobe. Release, then press 16'h1000 → mode=0, one mode_valid pulse; entry unchanged.
6. Press '4','2','*','#' → entry=0 after '*', no value_valid on '#'. Then hold '7' and assert rst mid-hold → all outputs 0; after reset, one new strobe with key_code=2 after 3 scans.

Source files
------------

// File: rtl/keypad_entry_decoder.sv
// Keypad entry decoder: debounces column-scanner bitmaps, emits one-cycle
// key events, and assembles decimal digits into a committed frequency value.
// Keys A-D select a waveform mode.
module keypad_entry_decoder #(
    parameter int N_COLUMN         = 4,
    parameter int N_ROW            = 4,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int MAX_DIGITS       = 6,
    parameter int VALUE_WIDTH      = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_COLUMN*N_ROW-1:0]    keys,
    input  logic                         keys_valid,
    output logic                         key_strobe,
    output logic [3:0]                   key_code,
    output logic [VALUE_WIDTH-1:0]       entry,
    output logic [2:0]                   digit_count,
    output logic [VALUE_WIDTH-1:0]       value,
    output logic                         value_valid,
    output logic [1:0]                   mode,
    output logic                         mode_valid,
    output logic                         entry_overflow
);

    localparam int NK = N_COLUMN * N_ROW;
    localparam int CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SAMPLES - 1);
    localparam int PW = VALUE_WIDTH + 4;

    typedef enum logic {RELEASED, PRESSED} state_t;

    logic [NK-1:0]  last_sample;
    logic [CW-1:0]  stable_cnt;
    logic [CW-1:0]  new_cnt;
    logic           stable;
    logic           one_hot;
    logic [3:0]     key_idx;
    state_t         state_q;
    state_t         state_d;
    logic           strobe_d;
    logic           is_digit;
    logic [3:0]     digit;
    logic [PW-1:0]  prod;

    // Debounce: count consecutive identical scans, saturating at the threshold.
    always_comb begin
        new_cnt = '0;
        if (keys == last_sample)
            new_cnt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CW'(1);
        stable = keys_valid && (new_cnt == CNT_MAX);
    end

    // Encode the pressed key index and detect a clean single-key pattern.
    always_comb begin
        key_idx = '0;
        for (int i = 0; i < NK; i++)
            if (keys[i]) key_idx = 4'(i);
        one_hot = ($countones(keys) == 1);
    end

    // Debounce history, only advanced on valid scans.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sample <= '0;
            stable_cnt  <= '0;
        end else if (keys_valid) begin
            last_sample <= keys;
            stable_cnt  <= new_cnt;
        end
    end

    // Press/release tracker: strobe once per clean press, lock out chords.
    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        if (stable) begin
            case (state_q)
                RELEASED: if (keys != '0) begin
                    state_d  = PRESSED;
                    strobe_d = one_hot;
                end
                PRESSED:  if (keys == '0) state_d = RELEASED;
                default:  state_d = RELEASED;
            endcase
        end
    end

    // FSM state and the registered key event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RELEASED;
            key_strobe <= 1'b0;
            key_code   <= '0;
        end else begin
            state_q    <= state_d;
            key_strobe <= strobe_d;
            if (strobe_d) key_code <= key_idx;
        end
    end

    // Map the physical key index to a decimal digit, if it is one.
    always_comb begin
        is_digit = 1'b1;
        digit    = '0;
        case (key_code)
            4'd0:    digit = 4'd1;
            4'd4:    digit = 4'd2;
            4'd8:    digit = 4'd3;
            4'd1:    digit = 4'd4;
            4'd5:    digit = 4'd5;
            4'd9:    digit = 4'd6;
            4'd2:    digit = 4'd7;
            4'd6:    digit = 4'd8;
            4'd10:   digit = 4'd9;
            4'd7:    digit = 4'd0;
            default: is_digit = 1'b0;
        endcase
        // Widened so the multiply cannot wrap before truncation.
        prod = PW'(entry) * PW'(10) + PW'(digit);
    end

    // Entry assembly, commit and mode selection, one cycle after the key event.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry          <= '0;
            digit_count    <= '0;
            value          <= '0;
            value_valid    <= 1'b0;
            mode           <= '0;
            mode_valid     <= 1'b0;
            entry_overflow <= 1'b0;
        end else begin
            value_valid    <= 1'b0;
            mode_valid     <= 1'b0;
            entry_overflow <= 1'b0;
            if (key_strobe) begin
                if (is_digit) begin
                    if (digit_count < 3'(MAX_DIGITS)) begin
                        entry       <= prod[VALUE_WIDTH-1:0];
                        digit_count <= digit_count + 3'd1;
                    end else begin
                        entry_overflow <= 1'b1;
                    end
                end else begin
                    case (key_code)
                        4'd3: begin
                            entry       <= '0;
                            digit_count <= '0;
                        end
                        4'd11: if (digit_count != '0) begin
                            value       <= entry;
                            value_valid <= 1'b1;
                            entry       <= '0;
                            digit_count <= '0;
                        end
                        default: begin
                            // Remaining keys are A-D at indices 12..15.
                            mode       <= key_code[1:0];
                            mode_valid <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// Directed bench for keypad_entry_decoder with hand-computed expectations.
module tb_keypad_entry_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;
    logic        keys_valid;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [19:0] entry;
    logic [2:0]  digit_count;
    logic [19:0] value;
    logic        value_valid;
    logic [1:0]  mode;
    logic        mode_valid;
    logic        entry_overflow;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0, n_vv = 0, n_mv = 0, n_ovf = 0;

    keypad_entry_decoder dut (
        .clk(clk), .rst(rst), .keys(keys), .keys_valid(keys_valid),
        .key_strobe(key_strobe), .key_code(key_code), .entry(entry),
        .digit_count(digit_count), .value(value), .value_valid(value_valid),
        .mode(mode), .mode_valid(mode_valid), .entry_overflow(entry_overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (key_strobe)     n_strobe++;
        if (value_valid)    n_vv++;
        if (mode_valid)     n_mv++;
        if (entry_overflow) n_ovf++;
    end

    task automatic scan(input logic [15:0] k);
        keys = k; keys_valid = 1'b1;
        @(posedge clk); #1;
        keys_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input int idx);
        logic [15:0] k;
        k = '0; k[idx] = 1'b1;
        repeat (3) scan(k);
        repeat (3) scan(16'h0000);
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; keys = 16'h0020; keys_valid = 1'b1;
        idle(3);
        rst = 1'b0; keys_valid = 1'b0; keys = '0;
        checks++;
        if ({key_strobe, key_code, entry, digit_count, value, value_valid,
             mode, mode_valid, entry_overflow} !== '0) begin
            errors++; $display("FAIL reset_outputs: entry=%0d value=%0d code=%0d mode=%0d, all must be 0",
                               entry, value, key_code, mode);
        end
        idle(2);
    endtask

    task automatic test_single_press();
        int s0;
        s0 = n_strobe;
        repeat (3) scan(16'h0020);
        checks++;
        if (key_strobe !== 1'b1 || key_code !== 4'd5) begin
            errors++; $display("FAIL press_strobe: strobe=%0b code=%0d, want 1/5", key_strobe, key_code);
        end
        scan(16'h0000);
        checks++;
        if (entry !== 20'd5 || digit_count !== 3'd1) begin
            errors++; $display("FAIL press_entry: entry=%0d count=%0d, want 5/1", entry, digit_count);
        end
        repeat (2) scan(16'h0000);
        idle(2);
        checks++;
        if (n_strobe - s0 !== 1) begin
            errors++; $display("FAIL press_count: strobes=%0d, want 1", n_strobe - s0);
        end
    endtask

    task automatic test_bounce();
        int s0;
        s0 = n_strobe;
        scan(16'h0020); scan(16'h0000); scan(16'h0020); scan(16'h0020);
        checks++;
        if (key_strobe !== 1'b0 || n_strobe !== s0) begin
            errors++; $display("FAIL bounce_early: strobe=%0b count=%0d, want 0/0", key_strobe, n_strobe - s0);
        end
        scan(16'h0020);
        checks++;
        if (key_strobe !== 1'b1) begin
            errors++; $display("FAIL bounce_fifth: strobe=%0b, want 1", key_strobe);
        end
        repeat (3) scan(16'h0000);
        idle(2);
        checks++;
        if (n_strobe - s0 !== 1) begin
            errors++; $display("FAIL bounce_count: strobes=%0d, want 1", n_strobe - s0);
        end
    endtask

    task automatic test_commit();
        int v0;
        press(3);
        checks++;
        if (entry !== 20'd0 || digit_count !== 3'd0) begin
            errors++; $display("FAIL star_clear: entry=%0d count=%0d, want 0/0", entry, digit_count);
        end
        press(0); press(4); press(8);
        checks++;
        if (entry !== 20'd123 || digit_count !== 3'd3) begin
            errors++; $display("FAIL digits_123: entry=%0d count=%0d, want 123/3", entry, digit_count);
        end
        v0 = n_vv;
        press(11);
        checks++;
        if (value !== 20'd123 || n_vv - v0 !== 1 || entry !== 20'd0 || digit_count !== 3'd0) begin
            errors++; $display("FAIL commit_123: value=%0d pulses=%0d entry=%0d count=%0d, want 123/1/0/0",
                               value, n_vv - v0, entry, digit_count);
        end
    endtask

    task automatic test_overflow();
        int o0;
        o0 = n_ovf;
        repeat (6) press(10);
        checks++;
        if (entry !== 20'd999999 || n_ovf !== o0) begin
            errors++; $display("FAIL six_nines: entry=%0d ovf=%0d, want 999999/0", entry, n_ovf - o0);
        end
        press(10);
        checks++;
        if (n_ovf - o0 !== 1 || entry !== 20'd999999 || digit_count !== 3'd6) begin
            errors++; $display("FAIL seventh_digit: ovf=%0d entry=%0d count=%0d, want 1/999999/6",
                               n_ovf - o0, entry, digit_count);
        end
        press(11);
        checks++;
        if (value !== 20'd999999) begin
            errors++; $display("FAIL commit_max: value=%0d, want 999999", value);
        end
    endtask

    task automatic test_multikey_mode();
        int s0, m0;
        press(6);
        s0 = n_strobe;
        repeat (5) scan(16'h0021);
        repeat (3) scan(16'h0000);
        idle(2);
        checks++;
        if (n_strobe !== s0) begin
            errors++; $display("FAIL chord_lockout: strobes=%0d, want 0", n_strobe - s0);
        end
        m0 = n_mv;
        press(14);
        checks++;
        if (mode !== 2'd2 || n_mv - m0 !== 1) begin
            errors++; $display("FAIL mode_c: mode=%0d pulses=%0d, want 2/1", mode, n_mv - m0);
        end
        press(12);
        checks++;
        if (mode !== 2'd0 || n_mv - m0 !== 2 || entry !== 20'd8 || digit_count !== 3'd1) begin
            errors++; $display("FAIL mode_a: mode=%0d pulses=%0d entry=%0d count=%0d, want 0/2/8/1",
                               mode, n_mv - m0, entry, digit_count);
        end
    endtask

    task automatic test_clear_and_reset();
        int v0, s0;
        press(1); press(4);
        checks++;
        if (entry !== 20'd842) begin
            errors++; $display("FAIL entry_842: entry=%0d, want 842", entry);
        end
        press(3);
        v0 = n_vv;
        press(11);
        checks++;
        if (entry !== 20'd0 || n_vv !== v0 || value !== 20'd999999) begin
            errors++; $display("FAIL empty_commit: entry=%0d pulses=%0d value=%0d, want 0/0/999999",
                               entry, n_vv - v0, value);
        end
        repeat (5) scan(16'h0004);
        checks++;
        if (key_code !== 4'd2 || entry !== 20'd7) begin
            errors++; $display("FAIL hold_seven: code=%0d entry=%0d, want 2/7", key_code, entry);
        end
        rst = 1'b1; keys = 16'h0004; keys_valid = 1'b1;
        idle(2);
        checks++;
        if ({key_strobe, key_code, entry, digit_count, value, value_valid,
             mode, mode_valid, entry_overflow} !== '0) begin
            errors++; $display("FAIL midreset_outputs: entry=%0d value=%0d code=%0d, all must be 0",
                               entry, value, key_code);
        end
        rst = 1'b0; keys_valid = 1'b0;
        s0 = n_strobe;
        scan(16'h0004); scan(16'h0004);
        checks++;
        if (key_strobe !== 1'b0) begin
            errors++; $display("FAIL rearm_early: strobe=%0b, want 0", key_strobe);
        end
        scan(16'h0004);
        checks++;
        if (key_strobe !== 1'b1 || key_code !== 4'd2) begin
            errors++; $display("FAIL rearm_strobe: strobe=%0b code=%0d, want 1/2", key_strobe, key_code);
        end
        repeat (3) scan(16'h0000);
        idle(2);
        checks++;
        if (n_strobe - s0 !== 1 || entry !== 20'd7) begin
            errors++; $display("FAIL rearm_entry: strobes=%0d entry=%0d, want 1/7", n_strobe - s0, entry);
        end
    endtask

    initial begin
        rst = 1'b1; keys = '0; keys_valid = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_commit();
        test_overflow();
        test_multikey_mode();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
